// File: rtl/gpu_pkg.sv
// ============================================================================
//  gpu_pkg : shared frame-buffer geometry, pixel/address types, raster timing.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package gpu_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;

  typedef logic [8:0]           coord_t;
  typedef logic [7:0]           pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    coord_t h_active;
    coord_t h_fp;
    coord_t h_sync;
    coord_t h_bp;
    coord_t v_active;
    coord_t v_fp;
    coord_t v_sync;
    coord_t v_bp;
  } video_timing_t;

endpackage

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
//  video_timing_gen : h/v raster counters, active flag, raw syncs, wrap strobe.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module video_timing_gen
  import gpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  video_timing_t timing,
  output coord_t        h_cnt,
  output coord_t        v_cnt,
  output logic          active,
  output logic          hsync_act,
  output logic          vsync_act,
  output logic          wrap
);

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;

  logic [9:0] h_tot, h_sync_start, h_sync_end;
  logic [9:0] v_tot, v_sync_start, v_sync_end;
  logic       h_last, v_last;

  // Ten-bit sums so totals above 511 cannot silently wrap.
  assign h_sync_start = {1'b0, timing.h_active} + {1'b0, timing.h_fp};
  assign h_sync_end   = h_sync_start + {1'b0, timing.h_sync};
  assign h_tot        = h_sync_end + {1'b0, timing.h_bp};
  assign v_sync_start = {1'b0, timing.v_active} + {1'b0, timing.v_fp};
  assign v_sync_end   = v_sync_start + {1'b0, timing.v_sync};
  assign v_tot        = v_sync_end + {1'b0, timing.v_bp};

  assign h_last = ({1'b0, h_cnt_q} == (h_tot - 10'd1));
  assign v_last = ({1'b0, v_cnt_q} == (v_tot - 10'd1));

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 9'd1;
      end else begin
        h_cnt_d = h_cnt_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign active    = (h_cnt_q < timing.h_active) && (v_cnt_q < timing.v_active);
  assign hsync_act = ({1'b0, h_cnt_q} >= h_sync_start) && ({1'b0, h_cnt_q} < h_sync_end);
  assign vsync_act = ({1'b0, v_cnt_q} >= v_sync_start) && ({1'b0, v_cnt_q} < v_sync_end);
  assign wrap      = pix_ce && h_last && v_last;

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
// ============================================================================
//  fb_scanout : raster scan-out with incremental frame-buffer address and a
//  one-pixel output stage. Optional colour bars via SCANOUT_TEST_PATTERN_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fb_scanout
  import gpu_pkg::*;
#(
  parameter int H_ACTIVE = FB_WIDTH,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = FB_HEIGHT,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 6,
  parameter bit SYNC_POL = 1'b0
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [16:0] fb_rd_addr,
  input  logic [7:0]  fb_rd_data,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic [7:0]  vid_pixel,
  output logic        frame_start
);

  localparam video_timing_t C_TIMING = '{
    h_active: coord_t'(H_ACTIVE), h_fp: coord_t'(H_FP),
    h_sync:   coord_t'(H_SYNC),   h_bp: coord_t'(H_BP),
    v_active: coord_t'(V_ACTIVE), v_fp: coord_t'(V_FP),
    v_sync:   coord_t'(V_SYNC),   v_bp: coord_t'(V_BP)
  };

  coord_t h_cnt, v_cnt;
  logic   active, hsync_act, vsync_act, wrap;

  video_timing_gen u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .timing    (C_TIMING),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .wrap      (wrap)
  );

  fb_addr_t addr_q, addr_d;
  pixel_t   pixel_q, pixel_d;
  pixel_t   src_pixel;
  logic     de_q, de_d;
  logic     hsync_q, hsync_d;
  logic     vsync_q, vsync_d;
  logic     frame_start_q, frame_start_d;
  logic     last_active;

  assign last_active = (h_cnt == coord_t'(H_ACTIVE - 1)) && (v_cnt == coord_t'(V_ACTIVE - 1));

  // The current counters are the position whose pixel is being captured.
  always_comb begin
    src_pixel = fb_rd_data;
`ifdef SCANOUT_TEST_PATTERN_EN
    if (test_pattern) src_pixel = {h_cnt[8:6], v_cnt[7:6], 3'b000};
`endif
  end

  always_comb begin
    addr_d        = addr_q;
    pixel_d       = pixel_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = wrap;
    if (pix_ce) begin
      // Leaving the last visible pixel parks the address at 0, prefetching the next frame.
      if (active)    addr_d = last_active ? '0 : addr_q + 17'd1;
      else if (wrap) addr_d = '0;
      de_d    = active;
      pixel_d = active ? src_pixel : '0;
      hsync_d = hsync_act ? SYNC_POL : ~SYNC_POL;
      vsync_d = vsync_act ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      pixel_q       <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      pixel_q       <= pixel_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_rd_addr  = addr_q;
  assign vid_pixel   = pixel_q;
  assign vid_de      = de_q;
  assign vid_hsync   = hsync_q;
  assign vid_vsync   = vsync_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
// ============================================================================
//  tb_fb_scanout : randomized bench for fb_scanout on a reduced raster.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fb_scanout;

  localparam int HA  = 20;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 4;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        test_pattern = 1'b0;
  logic [16:0] fb_rd_addr;
  logic [7:0]  fb_rd_data;
  logic        vid_hsync, vid_vsync, vid_de, frame_start;
  logic [7:0]  vid_pixel;

  always #5 clk = ~clk;

  // Asynchronous-read frame buffer whose content is the low address byte.
  assign fb_rd_data = fb_rd_addr[7:0];

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_ce       (pix_ce),
`ifdef SCANOUT_TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .fb_rd_addr   (fb_rd_addr),
    .fb_rd_data   (fb_rd_data),
    .vid_hsync    (vid_hsync),
    .vid_vsync    (vid_vsync),
    .vid_de       (vid_de),
    .vid_pixel    (vid_pixel),
    .frame_start  (frame_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference raster position and expected registered outputs.
  int         mh = 0, mv = 0;
  bit         e_de = 0, e_hs = 1, e_vs = 1, e_fs = 0;
  logic [7:0] e_pix = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t, pos=%0d,%0d)", tag, got, exp, $time, mh, mv);
    end
  endtask

  // Address of the next active pixel in raster order (0 after the last one).
  function automatic int exp_addr(input int h, input int v);
    if (v >= VA) return 0;
    if (h < HA) return v * HA + h;
    if (v == VA - 1) return 0;
    return (v + 1) * HA;
  endfunction

  function automatic logic [7:0] exp_pixel(input int h, input int v, input bit tp);
    logic [8:0] hh, vv;
    hh = 9'(h);
    vv = 9'(v);
    if (tp) return {hh[8:6], vv[7:6], 3'b000};
    return 8'((v * HA + h) % 256);
  endfunction

  task automatic step();
    bit act, tp;
    @(posedge clk);
    tp = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
    tp = test_pattern;
`endif
    if (reset) begin
      mh = 0; mv = 0;
      e_de = 0; e_pix = '0; e_hs = 1; e_vs = 1; e_fs = 0;
    end else if (pix_ce) begin
      act   = (mh < HA) && (mv < VA);
      e_de  = act;
      e_pix = act ? exp_pixel(mh, mv, tp) : 8'd0;
      e_hs  = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
      e_vs  = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
      e_fs  = (mh == HT - 1) && (mv == VT - 1);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end else begin
      e_fs = 0;
    end
    @(negedge clk);
    check("fb_rd_addr", int'(fb_rd_addr), exp_addr(mh, mv));
    check("vid_de", int'(vid_de), int'(e_de));
    check("vid_pixel", int'(vid_pixel), int'(e_pix));
    check("vid_hsync", int'(vid_hsync), int'(e_hs));
    check("vid_vsync", int'(vid_vsync), int'(e_vs));
    check("frame_start", int'(frame_start), int'(e_fs));
  endtask

  initial begin
    int  de_c, hs_c, vs_c, fs_c;
    bit  found, did_mid;

    // Reset held for three clocks with the pixel enable running.
    @(negedge clk);
    reset = 1'b1; pix_ce = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("reset_addr", int'(fb_rd_addr), 0);
    check("reset_de", int'(vid_de), 0);
    check("reset_hsync", int'(vid_hsync), 1);
    check("reset_vsync", int'(vid_vsync), 1);
    reset = 1'b0;

    // Continuous enable: measure one full frame starting at a frame_start pulse.
    found = 1'b0;
    for (int i = 0; i < HT * VT + 4 && !found; i++) begin
      step();
      if (frame_start) found = 1'b1;
    end
    check("frame_start_seen", int'(found), 1);
    de_c = int'(vid_de); hs_c = int'(!vid_hsync); vs_c = int'(!vid_vsync); fs_c = int'(frame_start);
    for (int i = 1; i < HT * VT; i++) begin
      step();
      de_c += int'(vid_de);
      hs_c += int'(!vid_hsync);
      vs_c += int'(!vid_vsync);
      fs_c += int'(frame_start);
    end
    check("de_clks_per_frame", de_c, HA * VA);
    check("hsync_clks_per_frame", hs_c, HS * VT);
    check("vsync_clks_per_frame", vs_c, VS * HT);
    check("frame_starts_per_frame", fs_c, 1);

    // Enable on every third clock.
    for (int i = 0; i < HT * VT * 3 + 60; i++) begin
      pix_ce = (i % 3 == 0);
      step();
    end

    // Random enable duty, mid-frame reset and occasional random resets.
    did_mid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      pix_ce = 1'($urandom_range(0, 1));
      reset  = 1'b0;
      if (!did_mid && mv == 3 && mh == 10) begin
        reset = 1'b1;
        did_mid = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        reset = 1'b1;
      end
`ifdef SCANOUT_TEST_PATTERN_EN
      if ($urandom_range(0, 199) == 0) test_pattern = ~test_pattern;
`endif
      step();
    end
    check("mid_frame_reset_hit", int'(did_mid), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
